// File: rtl/alu_capture_if.sv
// Request/response bus between a requester and the alu_capture block.
interface alu_capture_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_cmd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic        rsp_timeout;
    logic [7:0]  rsp_latency;

    modport master (
        output req_valid, req_a, req_b, req_cmd, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero,
               rsp_overflow, rsp_timeout, rsp_latency
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cmd, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carryout, rsp_zero,
               rsp_overflow, rsp_timeout, rsp_latency
    );
endinterface

// File: rtl/alu_capture.sv
// Registers an ALU request, waits for the ALU output to stay unchanged for
// STABLE_CYCLES samples (or MAX_CYCLES budget), then presents the captured result.

module alu (
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [2:0]  command,
    output logic [31:0] result,
    output logic        carryout,
    output logic        zero,
    output logic        overflow
);
    logic        sub;
    logic [31:0] b_in;
    logic [31:0] sum;
    logic        sum_c;
    logic        sum_v;

    // SUB and SLT share the adder in subtract mode
    assign sub  = (command == 3'd1) || (command == 3'd3);
    assign b_in = sub ? ~operand_b : operand_b;
    assign {sum_c, sum} = {1'b0, operand_a} + {1'b0, b_in} + {32'd0, sub};
    assign sum_v = (operand_a[31] == b_in[31]) && (sum[31] != operand_a[31]);

    always_comb begin
        result   = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (command)
            3'd0: begin
                result   = sum;
                carryout = sum_c;
                overflow = sum_v;
            end
            3'd1: begin
                result   = sum;
                carryout = sum_c;
                overflow = sum_v;
            end
            3'd2: result = operand_a ^ operand_b;
            3'd3: result = {31'd0, sum[31] ^ sum_v};
            3'd4: result = operand_a & operand_b;
            3'd5: result = ~(operand_a & operand_b);
            3'd6: result = ~(operand_a | operand_b);
            3'd7: result = operand_a | operand_b;
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);
endmodule

module alu_capture #(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned MAX_CYCLES    = 255
) (
    input logic          clk,
    input logic          rst_n,
    alu_capture_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] opa;
    logic [31:0] opb;
    logic [2:0]  cmd;
    logic [7:0]  k;
    logic [7:0]  stable;
    logic [7:0]  chg;
    logic [34:0] prev;
    logic [34:0] snap;

    logic [31:0] alu_result;
    logic        alu_c;
    logic        alu_z;
    logic        alu_v;

    logic        accept;
    logic        settled;
    logic        expired;

    logic [31:0] rsp_result_q;
    logic        rsp_c_q;
    logic        rsp_z_q;
    logic        rsp_v_q;
    logic        rsp_t_q;
    logic [7:0]  rsp_lat_q;

    alu u_alu (
        .operand_a (opa),
        .operand_b (opb),
        .command   (cmd),
        .result    (alu_result),
        .carryout  (alu_c),
        .zero      (alu_z),
        .overflow  (alu_v)
    );

    assign snap = {alu_result, alu_c, alu_z, alu_v};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        settled       = 1'b0;
        expired       = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept   = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                // completion wins over the budget running out on the same edge
                if ((k != 8'd0) && (snap == prev) &&
                    ((stable + 8'd1) == 8'(STABLE_CYCLES))) begin
                    settled = 1'b1;
                end else if (k == 8'(MAX_CYCLES - 1)) begin
                    expired = 1'b1;
                end
                if (settled || expired) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa          <= '0;
            opb          <= '0;
            cmd          <= '0;
            k            <= '0;
            stable       <= '0;
            chg          <= '0;
            prev         <= '0;
            rsp_result_q <= '0;
            rsp_c_q      <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp_v_q      <= 1'b0;
            rsp_t_q      <= 1'b0;
            rsp_lat_q    <= '0;
        end else if (accept) begin
            opa    <= bus.req_a;
            opb    <= bus.req_b;
            cmd    <= bus.req_cmd;
            k      <= '0;
            stable <= '0;
            chg    <= '0;
        end else if (state == SETTLE) begin
            k <= k + 8'd1;
            if (k == 8'd0) begin
                prev   <= snap;
                stable <= '0;
            end else if (snap == prev) begin
                stable <= stable + 8'd1;
            end else begin
                prev   <= snap;
                stable <= '0;
                chg    <= k;
            end

            if (settled) begin
                {rsp_result_q, rsp_c_q, rsp_z_q, rsp_v_q} <= prev;
                rsp_t_q   <= 1'b0;
                rsp_lat_q <= chg;
            end else if (expired) begin
                {rsp_result_q, rsp_c_q, rsp_z_q, rsp_v_q} <= snap;
                rsp_t_q   <= 1'b1;
                rsp_lat_q <= 8'(MAX_CYCLES);
            end
        end
    end

    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_carryout = rsp_c_q;
    assign bus.rsp_zero     = rsp_z_q;
    assign bus.rsp_overflow = rsp_v_q;
    assign bus.rsp_timeout  = rsp_t_q;
    assign bus.rsp_latency  = rsp_lat_q;
endmodule

// File: tb/tb_alu_capture.sv
// Scoreboard bench for alu_capture: expected responses are queued at issue
// and popped when the block presents rsp_valid.
module tb_alu_capture;
    localparam int unsigned STABLE = 3;
    localparam int unsigned MAXC   = 255;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
        logic        t;
        logic [7:0]  lat;
    } exp_t;

    logic clk;
    logic rst_n;
    alu_capture_if bus ();

    alu_capture #(.STABLE_CYCLES(STABLE), .MAX_CYCLES(MAXC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    exp_t sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] s;
        e = '0;
        case (c)
            3'd0: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[31:0];
                e.c   = s[32];
                e.v   = (a[31] == b[31]) && (s[31] != a[31]);
            end
            3'd1: begin
                s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.res = s[31:0];
                e.c   = s[32];
                e.v   = (a[31] != b[31]) && (s[31] != a[31]);
            end
            3'd2: e.res = a ^ b;
            3'd3: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: e.res = a & b;
            3'd5: e.res = ~(a & b);
            3'd6: e.res = ~(a | b);
            default: e.res = a | b;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("issue_ready", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cmd   = c;
        sb.push_back(model(c, a, b));
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int unsigned edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!bus.rsp_valid && edges < 300);
        if (!bus.rsp_valid) check("rsp_wait", {63'd0, bus.rsp_valid}, 64'd1);
    endtask

    task automatic compare_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, ".result"},   64'(bus.rsp_result),   64'(e.res));
        check({tag, ".carryout"}, 64'(bus.rsp_carryout), 64'(e.c));
        check({tag, ".zero"},     64'(bus.rsp_zero),     64'(e.z));
        check({tag, ".overflow"}, 64'(bus.rsp_overflow), 64'(e.v));
        check({tag, ".timeout"},  64'(bus.rsp_timeout),  64'(e.t));
        check({tag, ".latency"},  64'(bus.rsp_latency),  64'(e.lat));
    endtask

    task automatic release_rsp(input string tag);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".ready_after"}, 64'(bus.req_ready), 64'd1);
        check({tag, ".valid_after"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned edges;
        issue(c, a, b);
        wait_rsp(edges);
        check({tag, ".edges"}, 64'(edges), 64'(STABLE + 1));
        compare_rsp(tag);
        release_rsp(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_ready"}, 64'(bus.req_ready),    64'd1);
        check({tag, ".rsp_valid"}, 64'(bus.rsp_valid),    64'd0);
        check({tag, ".result"},    64'(bus.rsp_result),   64'd0);
        check({tag, ".flags"},     64'({bus.rsp_carryout, bus.rsp_zero, bus.rsp_overflow, bus.rsp_timeout}), 64'd0);
        check({tag, ".latency"},   64'(bus.rsp_latency),  64'd0);
    endtask

    initial begin
        int unsigned edges;
        exp_t held;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cmd   = '0;
        bus.rsp_ready = 1'b0;
        #1;
        check_reset_outputs("in_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("idle");

        run_op("add", 3'd0, 32'd0, 32'hFFFF_FFFF);
        run_op("sub", 3'd1, 32'd0, 32'd1);
        run_op("slt", 3'd3, 32'd0, 32'd1);
        run_op("or0", 3'd7, 32'd0, 32'd0);
        run_op("and", 3'd4, 32'd1, 32'd1);
        run_op("addv", 3'd0, 32'h7FFF_FFFF, 32'd1);
        run_op("addc", 3'd0, 32'hFFFF_FFFF, 32'd1);
        run_op("subv", 3'd1, 32'h8000_0000, 32'd1);
        run_op("sltn", 3'd3, 32'h8000_0000, 32'd1);
        run_op("nand", 3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run_op("nor", 3'd6, 32'h0000_0000, 32'h0000_0000);
        for (int i = 0; i < 8; i++) begin
            run_op("rnd", 3'(i), $urandom, $urandom);
        end

        // response held under backpressure while the requester keeps poking
        issue(3'd0, 32'd5, 32'd7);
        wait_rsp(edges);
        check("bp.edges", 64'(edges), 64'(STABLE + 1));
        held = sb[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.req_valid = ~bus.req_valid;
            bus.req_a     = $urandom;
            @(negedge clk);
            check("bp.result",    64'(bus.rsp_result), 64'(held.res));
            check("bp.req_ready", 64'(bus.req_ready),  64'd0);
            check("bp.rsp_valid", 64'(bus.rsp_valid),  64'd1);
        end
        bus.req_valid = 1'b0;
        compare_rsp("bp");
        release_rsp("bp");
        run_op("bp_next", 3'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F);

        // reset two cycles into SETTLE abandons the operation
        issue(3'd0, 32'd1, 32'd2);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst.no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");
        run_op("xor0", 3'd2, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
